// File: rtl/ibex_lsu_split.sv
// rtl/ibex_lsu_split.sv - load/store unit that splits misaligned accesses into two word-aligned bus transactions
//
// Purpose:
//   Captures one load/store request from ID/EX, drives an OBI-style 32-bit data bus,
//   splits accesses that cross a word boundary into two aligned transactions, realigns
//   and sign/zero-extends load data, and reports bus errors. One instruction at a time.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   lsu_req_i                      request from ID (sampled in IDLE only)
//   lsu_we_i, lsu_type_i           store flag; access size (00 word, 01 half, 10 byte, 11 word)
//   lsu_sign_ext_i                 sign-extend load result
//   lsu_wdata_i                    LSB-aligned store data
//   adder_result_ex_i              byte address from EX adder
//   data_req_o/gnt_i/rvalid_i/err_i  bus handshake
//   data_addr_o, data_we_o, data_be_o, data_wdata_o, data_rdata_i  bus payload
//   lsu_resp_valid_o               instruction finished pulse
//   lsu_rdata_valid_o, lsu_rdata_o load data valid pulse, extended load result
//   load_err_o, store_err_o        bus error pulses
//   busy_o                         FSM not idle

module ibex_lsu_split (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic        lsu_resp_valid_o,
  output logic        lsu_rdata_valid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, REQ1, RV1, REQ2, RV2} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  type_q, type_d;
  logic        sign_ext_q, sign_ext_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;

  logic [1:0]  off;
  logic [4:0]  sh;
  logic [3:0]  base_mask;
  logic [7:0]  be_full;
  logic        split;
  logic [63:0] wdata_dup;
  logic [31:0] wdata_rot;
  logic [63:0] rdata_pair;
  logic [31:0] w;
  logic [31:0] ext;
  logic        resp;
  logic        resp_err;

  assign off = addr_q[1:0];
  assign sh  = {off, 3'b000};

  always_comb begin
    case (type_q)
      2'b01:   base_mask = 4'b0011;
      2'b10:   base_mask = 4'b0001;
      default: base_mask = 4'b1111;
    endcase
  end

  // Upper nibble of be_full is the part that spills into the next word.
  assign be_full = {4'b0000, base_mask} << off;
  assign split   = |be_full[7:4];

  // Rotate left by 8*off: upper half of the duplicated word shifted left.
  assign wdata_dup = {wdata_q, wdata_q} << sh;
  assign wdata_rot = wdata_dup[63:32];

  // RV2 is only reachable for split accesses, so it always combines both beats.
  assign rdata_pair = {data_rdata_i, rdata_q} >> sh;
  assign w = (state_q == RV2) ? rdata_pair[31:0] : (data_rdata_i >> sh);

  always_comb begin
    case (type_q)
      2'b10:   ext = {{24{sign_ext_q & w[7]}}, w[7:0]};
      2'b01:   ext = {{16{sign_ext_q & w[15]}}, w[15:0]};
      default: ext = w;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    type_d       = type_q;
    sign_ext_d   = sign_ext_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    data_req_o   = 1'b0;
    data_addr_o  = 32'h0;
    data_we_o    = 1'b0;
    data_be_o    = 4'b0000;
    data_wdata_o = 32'h0;
    resp         = 1'b0;
    resp_err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          addr_d     = adder_result_ex_i;
          we_d       = lsu_we_i;
          type_d     = lsu_type_i;
          sign_ext_d = lsu_sign_ext_i;
          wdata_d    = lsu_wdata_i;
          state_d    = REQ1;
        end
      end
      REQ1: begin
        data_req_o   = 1'b1;
        data_addr_o  = {addr_q[31:2], 2'b00};
        data_be_o    = be_full[3:0];
        data_we_o    = we_q;
        data_wdata_o = wdata_rot;
        if (data_gnt_i) state_d = RV1;
      end
      RV1: begin
        if (data_rvalid_i) begin
          if (data_err_i) begin
            resp     = 1'b1;
            resp_err = 1'b1;
            state_d  = IDLE;
          end else if (split) begin
            rdata_d = data_rdata_i;
            state_d = REQ2;
          end else begin
            resp    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      REQ2: begin
        data_req_o   = 1'b1;
        data_addr_o  = {addr_q[31:2] + 30'd1, 2'b00};
        data_be_o    = be_full[7:4];
        data_we_o    = we_q;
        data_wdata_o = wdata_rot;
        if (data_gnt_i) state_d = RV2;
      end
      RV2: begin
        if (data_rvalid_i) begin
          resp     = 1'b1;
          resp_err = data_err_i;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lsu_resp_valid_o  = resp;
    lsu_rdata_valid_o = resp & ~we_q & ~resp_err;
    load_err_o        = resp & ~we_q & resp_err;
    store_err_o       = resp & we_q & resp_err;
    lsu_rdata_d       = lsu_rdata_valid_o ? ext : lsu_rdata_q;
    lsu_rdata_o       = lsu_rdata_d;
  end

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      we_q        <= 1'b0;
      type_q      <= 2'b00;
      sign_ext_q  <= 1'b0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      lsu_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      type_q      <= type_d;
      sign_ext_q  <= sign_ext_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

endmodule

// File: doc/ibex_lsu_split.md
# ibex_lsu_split

- Load/store unit: sits directly downstream of the execute block.
- Takes the address computed by the EX ALU adder and the store data/type from ID, and drives the OBI-style data bus.
- Splits misaligned accesses into two word-aligned bus transactions.
- Realigns and sign/zero-extends load data for writeback, and reports bus errors.
- Handles one instruction at a time; no bus pipelining.

## Interface

Parameters:
- none; data bus fixed at 32 bits

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- lsu_req_i  in  1  request from ID; sampled only in IDLE
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_type_i  in  2  00 word, 01 half, 10 byte, 11 treated as word
- lsu_sign_ext_i  in  1  sign-extend load result
- lsu_wdata_i  in  32  store data, LSB-aligned
- adder_result_ex_i  in  32  byte address from EX ALU adder
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  bus response valid
- data_err_i  in  1  bus error, qualified by data_rvalid_i
- data_addr_o  out  32  word-aligned bus address ([1:0] always 00)
- data_we_o  out  1  bus write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  realigned store data
- data_rdata_i  in  32  bus read data, qualified by data_rvalid_i
- lsu_resp_valid_o  out  1  instruction finished (success or error); one-cycle pulse
- lsu_rdata_valid_o  out  1  load data valid; pulse, loads without error only
- lsu_rdata_o  out  32  extended load result
- load_err_o  out  1  load bus error; pulse
- store_err_o  out  1  store bus error; pulse
- busy_o  out  1  state != IDLE

## Operation

- FSM states: IDLE, REQ1, RV1, REQ2, RV2.
- **IDLE:** lsu_req_i=1 captures address, we, type, sign_ext and wdata into registers, then goes to REQ1.
- **Offset and mask:**
  - off = addr[1:0].
  - Base mask: byte 0001, half 0011, word 1111.
  - be_full[7:0] = mask << off.
  - split = |be_full[7:4] (word with off≠0, or half with off=3).
- **REQ1:**
  - data_req_o=1, data_addr_o={addr[31:2],00}, data_be_o=be_full[3:0].
  - data_wdata_o = captured wdata rotated left by 8·off.
  - data_we_o = captured we.
  - Move to RV1 on data_gnt_i. Outputs hold stable until then.
- **RV1:**
  - On data_rvalid_i with data_err_i: respond with error; go to IDLE; phase 2 is skipped.
  - On data_rvalid_i, no error, split: store data_rdata_i in rdata_q; go to REQ2.
  - On data_rvalid_i, no error, no split: respond; go to IDLE.
- **REQ2:** same as REQ1, except data_addr_o={addr[31:2]+1,00} (wraps modulo 2^32) and data_be_o=be_full[7:4]. Move to RV2 on data_gnt_i.
- **RV2:** on data_rvalid_i, respond (error if data_err_i); go to IDLE.
- **Load result (combinational in response cycle):**
  - Split: w = ({rdata_i, rdata_q} >> 8·off)[31:0].
  - Aligned: w = rdata_i >> 8·off.
  - Byte: w[7:0], extended from bit 7 if sign_ext else zero-extended.
  - Half: w[15:0], extended from bit 15 if sign_ext else zero-extended.
  - Word: w.
- **Response cycle:**
  - lsu_resp_valid_o=1.
  - lsu_rdata_valid_o = !we && !err.
  - load_err_o = !we && err; store_err_o = we && err.
- **lsu_rdata_o:** driven with the extended result in a response cycle; holds the last loaded value otherwise (registered copy).
- **Ignored inputs:**
  - lsu_req_i while busy_o=1 (protocol violation; bench asserts it never happens).
  - data_rvalid_i in IDLE, REQ1 and REQ2.
  - data_gnt_i outside REQ1 and REQ2.

## Timing

- **Reset values:**
  - FSM in IDLE; every captured register and rdata_q cleared to 0.
  - data_req_o, data_we_o and busy_o are 0; data_addr_o, data_be_o and data_wdata_o are 0.
  - All response pulses are 0; lsu_rdata_o is 0.
- **Reset mid-operation:** returns to IDLE immediately. data_req_o drops asynchronously. Any in-flight response is dropped.
- **Aligned access, zero-wait bus:**
  - cycle 0: lsu_req_i.
  - cycle 1: data_req_o with data_gnt_i.
  - cycle 2: data_rvalid_i and lsu_resp_valid_o, same cycle.
  - busy_o is high in cycles 1–2; a new lsu_req_i is accepted in cycle 3.
- **Split access, zero-wait bus:** responds in cycle 4 (REQ1, RV1, REQ2, RV2).
- **Wait states:** each cycle of gnt or rvalid delay adds one cycle.
- **Response pulses:** exactly one cycle, combinational from data_rvalid_i in RV1/RV2.
- **Bus response ordering:** rvalid arrives no earlier than the cycle after gnt. Per this bus contract, gnt and rvalid for the same transaction never coincide.

## Test plan

- **Aligned word load:** addr 0x100, rdata 0xDEADBEEF, zero-wait.
  - Expect be 1111, addr 0x100.
  - lsu_rdata_o=0xDEADBEEF with rdata_valid in cycle 2.
- **Signed byte load:** addr 0x103, sign_ext=1, rdata 0x80FF_0000.
  - Expect be 1000.
  - Result 0xFFFFFF80; with sign_ext=0, result 0x00000080.
- **Misaligned word store:** addr 0x202, wdata 0x11223344.
  - Phase 1: addr 0x200, be 1100, wdata 0x33441122.
  - Phase 2: addr 0x204, be 0011, same wdata.
  - resp_valid in cycle 4, store_err_o=0.
- **Misaligned half load at wrap-around:** addr 0xFFFFFFFF, rdata1 0xAB000000, rdata2 0x000000CD, sign_ext=0.
  - Phase 2 addr is 0x00000000.
  - Result 0x0000CDAB.
- **Error in phase 1 of a split load:**
  - data_err_i with rvalid in RV1 → load_err_o pulse, no REQ2, rdata_valid=0, busy_o low next cycle.
  - Store with error in RV2 → store_err_o pulse.
- **Wait states and reset:** gnt delayed 3 cycles.
  - data_req_o, data_addr_o, data_be_o and data_wdata_o stay stable until gnt.
  - rst_ni asserted in RV1 → data_req_o=0 and busy_o=0 immediately.
  - rvalid arriving after reset produces no response pulse.
